// File: rtl/swarm_host_ctrl.sv
// swarm_host_ctrl: host-side run controller for the solver swarm.
// Buffers CNF literals and broadcasts them to every core (each core may take
// the head on a different cycle), sequences start/halt/abort/timeout, and
// latches the first finishing core's result.
module swarm_host_ctrl #(
    parameter int NUM_CORES       = 4,
    parameter int LOAD_FIFO_DEPTH = 16,
    parameter int CYCLE_W         = 48,
    parameter int ID_W            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 host_start,
    input  logic                 host_abort,
    input  logic [CYCLE_W-1:0]   host_timeout_cycles,
    input  logic                 host_load_valid,
    input  logic signed [31:0]   host_load_literal,
    input  logic                 host_load_clause_end,
    output logic                 host_load_ready,
    output logic [NUM_CORES-1:0] core_load_valid,
    output logic signed [31:0]   core_load_literal,
    output logic                 core_load_clause_end,
    input  logic [NUM_CORES-1:0] core_load_ready,
    output logic                 core_start,
    output logic                 core_halt,
    input  logic [NUM_CORES-1:0] core_solve_done,
    input  logic [NUM_CORES-1:0] core_is_sat,
    input  logic [NUM_CORES-1:0] core_is_unsat,
    output logic                 host_busy,
    output logic                 host_done,
    output logic                 host_sat,
    output logic                 host_unsat,
    output logic                 host_timeout,
    output logic                 host_conflict,
    output logic [ID_W-1:0]      host_winner_id,
    output logic [CYCLE_W-1:0]   host_cycles
);

    localparam int AW = $clog2(LOAD_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, RUN, DONE} state_t;
    state_t state;

    // ---------------- load buffer + broadcast ----------------
    logic [32:0]          mem [LOAD_FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 fifo_empty, fifo_full, push, pop;
    logic [NUM_CORES-1:0] taken, accept;

    assign fifo_empty      = (count == '0);
    assign fifo_full       = (count == (AW+1)'(LOAD_FIFO_DEPTH));
    assign host_load_ready = !fifo_full && (state == IDLE);
    assign push            = host_load_valid && host_load_ready;
    assign core_load_valid = fifo_empty ? '0 : ~taken;
    assign accept          = core_load_valid & core_load_ready;
    // Head retires once every core has either taken it earlier or takes it now.
    assign pop             = !fifo_empty && (&(taken | core_load_ready));
    assign {core_load_literal, core_load_clause_end} = mem[rd_ptr];

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {host_load_literal, host_load_clause_end};
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Per-core "already has the head" flags, cleared when the head retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   taken <= '0;
        else if (pop) taken <= '0;
        else          taken <= taken | accept;
    end

    // ---------------- result decode ----------------
    logic [NUM_CORES-1:0] win;
    logic [ID_W-1:0]      win_id;
    logic                 any_win, any_sat, any_unsat, timeout_hit, go_run;

    assign win         = core_solve_done & (core_is_sat | core_is_unsat);
    assign any_win     = |win;
    assign any_sat     = |(win & core_is_sat);
    assign any_unsat   = |(win & core_is_unsat);
    assign timeout_hit = (host_timeout_cycles != '0) && (host_cycles == host_timeout_cycles);

    // Lowest-index winning core.
    always_comb begin
        win_id = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (win[i]) win_id = ID_W'(i);
        end
    end

    // Conditions that launch a run next cycle (abort always blocks them).
    always_comb begin
        go_run = 1'b0;
        case (state)
            IDLE:    go_run = host_start && !host_abort && fifo_empty;
            DRAIN:   go_run = !host_abort && fifo_empty;
            DONE:    go_run = host_start && !host_abort;
            default: go_run = 1'b0;
        endcase
    end

    // Run sequencer with registered outputs. host_cycles counts the RUN
    // cycles that did not end the run, so a timeout leaves it equal to the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            core_start     <= 1'b0;
            core_halt      <= 1'b0;
            host_busy      <= 1'b0;
            host_done      <= 1'b0;
            host_sat       <= 1'b0;
            host_unsat     <= 1'b0;
            host_timeout   <= 1'b0;
            host_conflict  <= 1'b0;
            host_winner_id <= '0;
            host_cycles    <= '0;
        end else begin
            core_start <= go_run;
            if (go_run) begin
                state          <= RUN;
                host_busy      <= 1'b1;
                core_halt      <= 1'b0;
                host_done      <= 1'b0;
                host_sat       <= 1'b0;
                host_unsat     <= 1'b0;
                host_timeout   <= 1'b0;
                host_conflict  <= 1'b0;
                host_winner_id <= '0;
                host_cycles    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        core_halt <= 1'b0;
                        if (host_start && !host_abort) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (host_abort) begin
                            state     <= IDLE;
                            core_halt <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (host_abort) begin
                            state     <= IDLE;
                            host_busy <= 1'b0;
                            core_halt <= 1'b1;
                        end else if (any_win) begin
                            state          <= DONE;
                            host_busy      <= 1'b0;
                            host_done      <= 1'b1;
                            core_halt      <= 1'b1;
                            host_winner_id <= win_id;
                            host_sat       <= core_is_sat[win_id];
                            host_unsat     <= core_is_unsat[win_id];
                            host_conflict  <= any_sat && any_unsat;
                        end else if (timeout_hit) begin
                            state        <= DONE;
                            host_busy    <= 1'b0;
                            host_done    <= 1'b1;
                            core_halt    <= 1'b1;
                            host_timeout <= 1'b1;
                        end else if (host_cycles != '1) begin
                            host_cycles <= host_cycles + 1'b1;
                        end
                    end
                    DONE: begin
                        if (host_abort) begin
                            state          <= IDLE;
                            core_halt      <= 1'b0;
                            host_done      <= 1'b0;
                            host_sat       <= 1'b0;
                            host_unsat     <= 1'b0;
                            host_timeout   <= 1'b0;
                            host_conflict  <= 1'b0;
                            host_winner_id <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_swarm_host_ctrl.sv
// Bench for swarm_host_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_swarm_host_ctrl;
    localparam int NC = 4, DEPTH = 16, CW = 48, IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic host_start, host_abort;
    logic [CW-1:0] host_timeout_cycles;
    logic host_load_valid, host_load_clause_end, host_load_ready;
    logic [31:0] host_load_literal;
    logic [NC-1:0] core_load_valid, core_load_ready;
    logic [31:0] core_load_literal;
    logic core_load_clause_end, core_start, core_halt;
    logic [NC-1:0] core_solve_done, core_is_sat, core_is_unsat;
    logic host_busy, host_done, host_sat, host_unsat, host_timeout, host_conflict;
    logic [IW-1:0] host_winner_id;
    logic [CW-1:0] host_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    swarm_host_ctrl #(.NUM_CORES(NC), .LOAD_FIFO_DEPTH(DEPTH), .CYCLE_W(CW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_start(host_start), .host_abort(host_abort),
        .host_timeout_cycles(host_timeout_cycles),
        .host_load_valid(host_load_valid), .host_load_literal(host_load_literal),
        .host_load_clause_end(host_load_clause_end), .host_load_ready(host_load_ready),
        .core_load_valid(core_load_valid), .core_load_literal(core_load_literal),
        .core_load_clause_end(core_load_clause_end), .core_load_ready(core_load_ready),
        .core_start(core_start), .core_halt(core_halt),
        .core_solve_done(core_solve_done), .core_is_sat(core_is_sat), .core_is_unsat(core_is_unsat),
        .host_busy(host_busy), .host_done(host_done), .host_sat(host_sat), .host_unsat(host_unsat),
        .host_timeout(host_timeout), .host_conflict(host_conflict),
        .host_winner_id(host_winner_id), .host_cycles(host_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 draining, 2 running, 3 result held
    logic [32:0]   mq[$];
    bit            m_got[NC];
    int            m_mode;
    bit            m_start, m_halt, m_sat, m_unsat, m_to, m_conf;
    int            m_wid;
    logic [CW-1:0] m_cyc;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NC; i++) m_got[i] = 1'b0;
        m_mode = 0; m_start = 0; m_halt = 0;
        m_sat = 0; m_unsat = 0; m_to = 0; m_conf = 0; m_wid = 0; m_cyc = '0;
    endtask

    task automatic clear_result();
        m_sat = 0; m_unsat = 0; m_to = 0; m_conf = 0; m_wid = 0;
    endtask

    task automatic enter_run();
        m_mode = 2; m_start = 1; m_cyc = '0;
        clear_result();
    endtask

    task automatic model_step();
        bit was_empty, do_push, all_have, pulse, found;
        bit [NC-1:0] win;
        if (!rst_n) begin
            model_reset();
        end else begin
            was_empty = (mq.size() == 0);
            do_push   = host_load_valid && (mq.size() < DEPTH) && (m_mode == 0);
            if (!was_empty) begin
                all_have = 1;
                for (int i = 0; i < NC; i++) if (!m_got[i] && !core_load_ready[i]) all_have = 0;
                if (all_have) begin
                    void'(mq.pop_front());
                    for (int i = 0; i < NC; i++) m_got[i] = 0;
                end else begin
                    for (int i = 0; i < NC; i++) if (core_load_ready[i]) m_got[i] = 1;
                end
            end
            if (do_push) mq.push_back({host_load_literal, host_load_clause_end});

            m_start = 0;
            pulse   = 0;
            win     = core_solve_done & (core_is_sat | core_is_unsat);
            case (m_mode)
                0: if (host_start && !host_abort) begin
                       if (was_empty) enter_run(); else m_mode = 1;
                   end
                1: if (host_abort) begin m_mode = 0; pulse = 1; end
                   else if (was_empty) enter_run();
                2: if (host_abort) begin m_mode = 0; pulse = 1; end
                   else if (win != 0) begin
                       m_mode = 3;
                       found = 0;
                       for (int i = 0; i < NC; i++) if (win[i] && !found) begin found = 1; m_wid = i; end
                       m_sat   = core_is_sat[m_wid];
                       m_unsat = core_is_unsat[m_wid];
                       m_conf  = ((win & core_is_sat) != 0) && ((win & core_is_unsat) != 0);
                       m_to    = 0;
                   end else if (host_timeout_cycles != 0 && m_cyc == host_timeout_cycles) begin
                       m_mode = 3; clear_result(); m_to = 1;
                   end else if (m_cyc != {CW{1'b1}}) begin
                       m_cyc = m_cyc + 1;
                   end
                default: if (host_abort) begin m_mode = 0; clear_result(); end
                         else if (host_start) enter_run();
            endcase
            m_halt = (m_mode == 3) || pulse;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NC-1:0] ev;
        for (int i = 0; i < NC; i++) ev[i] = (mq.size() > 0) && !m_got[i];
        chk("load_ready", host_load_ready, (mq.size() < DEPTH) && (m_mode == 0));
        chk("core_valid", core_load_valid, ev);
        if (mq.size() > 0) begin
            chk("core_literal", core_load_literal, mq[0][32:1]);
            chk("core_clause_end", core_load_clause_end, mq[0][0]);
        end
        chk("core_start", core_start, m_start);
        chk("core_halt", core_halt, m_halt);
        chk("busy", host_busy, m_mode == 2);
        chk("done", host_done, m_mode == 3);
        chk("sat", host_sat, m_sat);
        chk("unsat", host_unsat, m_unsat);
        chk("timeout", host_timeout, m_to);
        chk("conflict", host_conflict, m_conf);
        chk("winner_id", host_winner_id, m_wid);
        chk("cycles", host_cycles, m_cyc);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet_inputs();
        host_start = 0; host_abort = 0; host_timeout_cycles = '0;
        host_load_valid = 0; host_load_literal = '0; host_load_clause_end = 0;
        core_load_ready = '0; core_solve_done = '0; core_is_sat = '0; core_is_unsat = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] lits [5];
        int starts;
        lits[0] = 32'hFFFF_FFFF; lits[1] = 32'd2; lits[2] = 32'hFFFF_FFFD;
        lits[3] = 32'd4;         lits[4] = 32'd0;

        quiet_inputs();
        model_reset();
        cyc(); cyc();
        chk("rst_load_ready", host_load_ready, 1);
        chk("rst_halt", core_halt, 0);
        rst_n = 1'b1;
        cyc();

        // five literals, every core ready: one pop per cycle
        core_load_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            host_load_valid = 1; host_load_literal = lits[k]; host_load_clause_end = (k == 2 || k == 4);
            cyc();
            if (k == 0) begin
                chk("t1_head", core_load_literal, 32'hFFFF_FFFF);
                chk("t1_valid", core_load_valid, 4'hF);
            end
        end
        host_load_valid = 0;
        chk("t1_last_ce", core_load_clause_end, 1);
        cyc();
        chk("t1_empty", core_load_valid, 4'h0);

        // core 2 holds off on head literal 7
        core_load_ready = 4'h0;
        host_load_valid = 1; host_load_literal = 32'd7; host_load_clause_end = 0; cyc();
        host_load_literal = 32'd8; host_load_clause_end = 1; cyc();
        host_load_valid = 0;
        core_load_ready = 4'b1011;
        for (int k = 0; k < 3; k++) cyc();
        chk("t2_valid_core2", core_load_valid, 4'b0100);
        chk("t2_head7", core_load_literal, 32'd7);
        core_load_ready = 4'hF;
        cyc();
        chk("t2_head8", core_load_literal, 32'd8);
        cyc();
        core_load_ready = 4'h0;
        cyc();

        // start with three literals buffered -> drain, then one start pulse
        host_load_valid = 1;
        for (int k = 0; k < 3; k++) begin host_load_literal = 32'(k + 20); cyc(); end
        host_start = 1; cyc();
        host_start = 0;
        chk("t3_drain_ready", host_load_ready, 0);
        core_load_ready = 4'hF;
        starts = 0;
        for (int k = 0; k < 8; k++) begin cyc(); if (core_start) starts++; end
        chk("t3_start_pulses", starts, 1);
        host_load_valid = 0; core_load_ready = 4'h0;

        // core 1 sat and core 3 unsat together; core 0 done without a result
        core_solve_done = 4'b1011; core_is_sat = 4'b0010; core_is_unsat = 4'b1000;
        cyc();
        core_solve_done = '0; core_is_sat = '0; core_is_unsat = '0;
        chk("t4_done", host_done, 1);
        chk("t4_winner", host_winner_id, 1);
        chk("t4_sat", host_sat, 1);
        chk("t4_conflict", host_conflict, 1);
        chk("t4_halt", core_halt, 1);
        host_abort = 1; cyc(); host_abort = 0; cyc();

        // timeout of 10 with no finisher
        host_timeout_cycles = 48'd10;
        host_start = 1; cyc(); host_start = 0;
        for (int k = 0; k < 11; k++) cyc();
        chk("t5_timeout", host_timeout, 1);
        chk("t5_cycles", host_cycles, 48'd10);
        // re-solve; winner arrives at cycle 10, beats the timeout
        host_start = 1; cyc(); host_start = 0;
        for (int k = 0; k < 10; k++) cyc();
        core_solve_done = 4'b0100; core_is_unsat = 4'b0100;
        cyc();
        core_solve_done = '0; core_is_unsat = '0;
        chk("t5w_timeout", host_timeout, 0);
        chk("t5w_unsat", host_unsat, 1);
        chk("t5w_winner", host_winner_id, 2);
        chk("t5w_cycles", host_cycles, 48'd10);

        // abort mid-run, restart, then reset mid-run
        host_timeout_cycles = '0;
        host_start = 1; cyc(); host_start = 0;
        cyc(); cyc(); cyc();
        host_abort = 1; cyc(); host_abort = 0;
        chk("t6_abort_halt", core_halt, 1);
        chk("t6_abort_busy", host_busy, 0);
        cyc();
        chk("t6_halt_drop", core_halt, 0);
        host_start = 1; cyc(); host_start = 0;
        chk("t6_restart_pulse", core_start, 1);
        chk("t6_restart_cycles", host_cycles, 0);
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("t6_rst_busy", host_busy, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // fill the buffer past capacity, then drain it
        host_load_valid = 1;
        for (int k = 0; k < 20; k++) begin
            host_load_literal = $urandom; host_load_clause_end = $urandom_range(0, 1); cyc();
        end
        chk("full_ready", host_load_ready, 0);
        host_load_valid = 0; core_load_ready = 4'hF;
        for (int k = 0; k < 18; k++) cyc();
        chk("drained", core_load_valid, 4'h0);

        // random traffic
        host_timeout_cycles = 48'd12;
        for (int k = 0; k < 3000; k++) begin
            host_load_valid      = ($urandom_range(0, 3) != 0);
            host_load_literal    = $urandom;
            host_load_clause_end = $urandom_range(0, 1);
            core_load_ready      = 4'($urandom);
            host_start           = ($urandom_range(0, 15) == 0);
            host_abort           = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NC; i++) core_solve_done[i] = ($urandom_range(0, 9) == 0);
            core_is_sat   = 4'($urandom);
            core_is_unsat = 4'($urandom);
            if ($urandom_range(0, 199) == 0) host_timeout_cycles = 48'($urandom_range(0, 20));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/swarm_host_ctrl.md
# swarm_host_ctrl

Host-facing run controller for a parametrised solver swarm. It sits between the host interface and the NUM_CORES solver-core grid, and replaces the plain AND-ready load broadcast and combinational result OR.
- CNF load path: a buffered broadcast in which each core may accept the current literal on a different cycle.
- Run sequencing: start, halt, abort and timeout are sequenced from a single FSM.
- Result capture: the first finishing core's result and ID are latched, with a run cycle counter and a sat/unsat conflict flag.

## Interface
Parameters:
- NUM_CORES, 4, number of solver cores (≥1).
- LOAD_FIFO_DEPTH, 16, load buffer entries (power of 2, ≥2).
- CYCLE_W, 48, width of run cycle counter and timeout.
- ID_W, max(1,$clog2(NUM_CORES)), winner ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- host_start  in  1  start or restart a solve (level sampled per cycle).
- host_abort  in  1  abort run / clear result.
- host_timeout_cycles  in  CYCLE_W  run cycle limit; 0 = no limit.
- host_load_valid  in  1  literal valid.
- host_load_literal  in  32 signed  literal (0 permitted, passed through).
- host_load_clause_end  in  1  last literal of clause.
- host_load_ready  out  1  literal accepted when valid&ready.
- core_load_valid  out  NUM_CORES  per-core literal valid.
- core_load_literal  out  32  FIFO head literal, shared.
- core_load_clause_end  out  1  FIFO head clause_end, shared.
- core_load_ready  in  NUM_CORES  per-core accept.
- core_start  out  1  one-cycle start pulse to all cores.
- core_halt  out  1  stop all cores.
- core_solve_done, core_is_sat, core_is_unsat  in  NUM_CORES each  per-core status.
- host_busy  out  1  state is RUN.
- host_done  out  1  result valid (state DONE).
- host_sat, host_unsat, host_timeout, host_conflict  out  1 each  latched result flags.
- host_winner_id  out  ID_W  index of winning core.
- host_cycles  out  CYCLE_W  cycles spent in RUN (saturating).

## Operation
- FSM states: IDLE, DRAIN, RUN, DONE. Reset → IDLE.
- Load FIFO: 33-bit entries (literal, clause_end).
  - host_load_ready = !full && state==IDLE.
  - Write when valid&ready. Loads are refused in DRAIN, RUN and DONE.
- Broadcast, per core: taken[i] flag.
  - core_load_valid[i] = !empty && !taken[i].
  - taken[i] sets on valid[i]&ready[i].
  - Pop when every i has taken[i] or accepts this cycle. On pop, clear all taken.
- IDLE:
  - host_start with FIFO empty → RUN, pulsing core_start.
  - host_start with FIFO non-empty → DRAIN.
- DRAIN: when FIFO empty → RUN, pulsing core_start.
- RUN: a winning core is an index i with done[i] && (sat[i] || unsat[i]). Done without sat/unsat is ignored.
  - Any winner → DONE.
    - host_winner_id = lowest winning index; host_sat/host_unsat copied from it.
    - host_conflict=1 if, in the same cycle, any winner reports sat and any winner reports unsat.
  - Else timeout != 0 and host_cycles == timeout → DONE with host_timeout=1, sat/unsat=0.
- DONE:
  - Result flags held and core_halt=1.
  - host_start → clear flags, RUN with core_start pulse (re-solve same CNF).
  - host_abort → IDLE.
- Priority per cycle: host_abort > winner > timeout.
  - Abort in RUN or DRAIN → IDLE, core_halt=1 for exactly one cycle, result flags cleared, FIFO contents kept.
- host_cycles: cleared on entering RUN. Increments each RUN cycle and saturates at all-ones.

## Timing
- Reset values:
  - All registered outputs 0: core_start, core_halt, host_busy, host_done, all result flags, host_winner_id, host_cycles.
  - FIFO empty, taken all 0.
  - host_load_ready=1 (combinational).
- Load latency: a literal written in cycle t appears on core_load_* in cycle t+1 at the earliest. core_load_literal is stable while !empty and no pop.
- Throughput: one pop per cycle when all cores are ready.
- FIFO full: ready=0, no overwrite. Simultaneous push and pop when full is not possible (ready=0).
- core_start is asserted in the first RUN cycle, one cycle after the start condition is sampled.
- Result latency: winner sampled in cycle t → host_done, flags and core_halt high in t+1.
- rst_n asserted mid-run: immediate return to reset values. Cores see core_halt=0 and no start.

## Test plan
- NUM_CORES=4, stream 5 literals, cores 0–3 all ready → 5 pops over 5 cycles, each core sees literals in order, clause_end bits preserved.
- Core 2 ready withheld 3 cycles on head literal 7 → head held, cores 0/1/3 valid drops after acceptance, pop when core 2 accepts; no duplicate or lost literal.
- host_start with 3 literals buffered → DRAIN, then core_start pulse exactly once after the FIFO empties; host_load_ready=0 from DRAIN onward.
- Core 1 sat and core 3 unsat in the same cycle → host_done next cycle, winner_id=1, host_sat=1, host_conflict=1, core_halt=1.
- host_timeout_cycles=10, no core done → host_timeout=1 with host_cycles=10; the same test with a winner at cycle 10 → winner result, host_timeout=0.
- Abort during RUN → one-cycle core_halt, IDLE, flags 0; restart → host_cycles restarts from 0; rst_n pulse mid-run → all outputs at reset values.
